// File: rtl/vga_timing_gen.sv
// Raster timing generator: pixel-rate tick, x/y counters and registered
// sync / visible / frame_start decodes for a VGA-style display.
`timescale 1ns/1ps

module vga_timing_gen #(
  parameter int CLK_DIV   = 2,
  parameter int H_VISIBLE = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33
) (
  input  logic       clk,
  input  logic       rst,
  output logic       pix_tick,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       hsync,
  output logic       vsync,
  output logic       visible,
  output logic       frame_start
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0]       H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0]       V_LAST   = 10'(V_TOTAL - 1);

  // Decode bounds are one bit wider so a sync pulse ending at 1024 still compares correctly.
  localparam logic [10:0] HS_START = 11'(H_VISIBLE + H_FP);
  localparam logic [10:0] HS_END   = 11'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [10:0] VS_START = 11'(V_VISIBLE + V_FP);
  localparam logic [10:0] VS_END   = 11'(V_VISIBLE + V_FP + V_SYNC);
  localparam logic [10:0] H_VIS    = 11'(H_VISIBLE);
  localparam logic [10:0] V_VIS    = 11'(V_VISIBLE);

  logic [DIV_W-1:0] div;
  logic [DIV_W-1:0] div_next;
  logic [9:0]       x_next;
  logic [9:0]       y_next;
  logic [10:0]      xw;
  logic [10:0]      yw;

  // With CLK_DIV=1 the divider is stuck at 0 and the tick is permanently high.
  assign pix_tick = (div == DIV_LAST);

  always_comb begin
    // NOTE: every comb output gets a default first, so no path can infer a latch.
    div_next = (div == DIV_LAST) ? '0 : div + DIV_W'(1);
    x_next   = x;
    y_next   = y;
    if (pix_tick) begin
      if (x == H_LAST) begin
        x_next = '0;
        y_next = (y == V_LAST) ? '0 : y + 10'd1;
      end else begin
        x_next = x + 10'd1;
      end
    end
    xw = {1'b0, x_next};
    yw = {1'b0, y_next};
  end

  // Decodes are taken from the next x/y so they line up with the registered counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div         <= '0;
      x           <= H_LAST;
      y           <= V_LAST;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      visible     <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      div         <= div_next;
      x           <= x_next;
      y           <= y_next;
      hsync       <= !((xw >= HS_START) && (xw < HS_END));
      vsync       <= !((yw >= VS_START) && (yw < VS_END));
      visible     <= (xw < H_VIS) && (yw < V_VIS);
      frame_start <= (x_next == 10'd0) && (y_next == 10'd0);
    end
  end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Raster timing generator for the 640x480@60 Hz VGA output. It produces the horizontal and vertical syncs, a pixel-rate tick and the `visible` / `frame_start` qualifiers, plus the current pixel coordinates. It sits between the system clock and the pixel-drawing logic, which consumes `visible` and `frame_start` and drives the colour lines. It also drives the monitor's sync pins directly.

## Interface
Parameters:
- `CLK_DIV`, 2: system clocks per pixel; 50 MHz clk gives a 25 MHz pixel rate. Legal range ≥1.
- `H_VISIBLE`, 640: active pixels per line.
- `H_FP`, 16: horizontal front porch, in pixels.
- `H_SYNC`, 96: hsync pulse width, in pixels.
- `H_BP`, 48: horizontal back porch, in pixels.
- `V_VISIBLE`, 480: active lines per frame.
- `V_FP`, 10: vertical front porch, in lines.
- `V_SYNC`, 2: vsync pulse width, in lines.
- `V_BP`, 33: vertical back porch, in lines.

Derived values:
- H_TOTAL = H_VISIBLE+H_FP+H_SYNC+H_BP = 800.
- V_TOTAL = V_VISIBLE+V_FP+V_SYNC+V_BP = 525.
- Both totals must be ≤1024.

Ports:
- `clk` in 1: system clock. Everything is on its rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `pix_tick` out 1: high for one clk in every CLK_DIV clks; marks the pixel-advance cycle.
- `x` out 10: current horizontal count, 0..H_TOTAL-1.
- `y` out 10: current vertical count, 0..V_TOTAL-1.
- `hsync` out 1: horizontal sync, active low.
- `vsync` out 1: vertical sync, active low.
- `visible` out 1: high when x<H_VISIBLE and y<V_VISIBLE.
- `frame_start` out 1: high while x==0 and y==0 (one pixel period).

## Operation
- **Divider.** `div` counts 0..CLK_DIV-1 and wraps.
  - `pix_tick` = (div==CLK_DIV-1), decoded combinationally from the register.
  - With CLK_DIV=1, `pix_tick` is constantly 1.
- **Counters.** `x` and `y` are registers and change only on a clk edge where `pix_tick`=1.
  - `x` increments on each tick; at H_TOTAL-1 it wraps to 0.
  - `y` increments only when `x` wraps; at V_TOTAL-1 it wraps to 0 together with `x`.
- **Decoded outputs.** `hsync`, `vsync`, `visible` and `frame_start` are registered. They are computed from the next-state values of x/y, so they always correspond to the x/y present in the same cycle, with no glitches.
  - `hsync`=0 iff H_VISIBLE+H_FP ≤ x < H_VISIBLE+H_FP+H_SYNC, i.e. x = 656..751.
  - `vsync`=0 iff V_VISIBLE+V_FP ≤ y < V_VISIBLE+V_FP+V_SYNC, i.e. y = 490..491.
  - `vsync` changes only together with `y`, i.e. at a line boundary.
- **Reset.** On `rst`=0 (asynchronous) all state loads immediately:
  - div=0, x=H_TOTAL-1 (799), y=V_TOTAL-1 (524).
  - hsync=1, vsync=1, visible=0, frame_start=0.
  - pix_tick=0 when CLK_DIV>1.
  - These values are self-consistent with the decode of (799,524).
- **Reset mid-frame.** Asserting `rst` at any point abandons the frame. Outputs return to the reset values within the same cycle, with no partial sync pulse held.

## Timing
- **Frame period:** H_TOTAL·V_TOTAL·CLK_DIV clks = 840 000 clks at defaults.
- **Line period:** H_TOTAL·CLK_DIV = 1600 clks.
- **hsync pulse:** H_SYNC·CLK_DIV = 192 clks. Its falling edge comes 656 ticks after x=0.
- **vsync pulse:** V_SYNC lines = 3200 clks.
- **First frame after reset release (CLK_DIV=2):**
  - Cycle 0: div=0.
  - Cycle 1: div=1, pix_tick=1.
  - At the end of cycle 1, x,y wrap to (0,0). From cycle 2, `frame_start`=1 and `visible`=1, held for CLK_DIV clks.
- **Pixel spacing:** consecutive `frame_start` rising edges are exactly one frame period apart.
- **Visible count:** `visible` is high for 640·480 = 307 200 ticks per frame (614 400 clks at CLK_DIV=2). It is contiguous within each line, and x counts 0..639 monotonically during that span.
- **No events mid-pixel:** all output changes coincide with the edge following a `pix_tick`, except the asynchronous reset.

## Test plan
- **Reset values:** hold `rst`=0 and check x=799, y=524, hsync=1, vsync=1, visible=0, frame_start=0. Release; `frame_start` must rise exactly 2 clks later with x=0, y=0, visible=1.
- **Horizontal timing:** over one line, measure 1600 clks from x=0 to x=0. Check hsync is low for exactly 192 clks, starting at x=656 and ending after x=751, and visible is high for 1280 clks, covering x=0..639.
- **Vertical timing:** check vsync is low only while y=490..491 (3200 clks), and y wraps 524→0 at the same edge that x wraps 799→0.
- **Whole frame:** count clks between `frame_start` rising edges (840 000) and count `pix_tick` cycles with visible=1 per frame (307 200).
- **Mid-frame reset:** assert `rst` during the hsync pulse at y=100. Outputs must return to the reset values in the same cycle, hsync must return to 1, and the frame must restart with `frame_start` 2 clks after release.
- **CLK_DIV=1 variant:** pix_tick is constantly 1, the frame period is 420 000 clks, the hsync pulse is 96 clks, and `frame_start` rises 1 clk after reset release.
